// File: rtl/fifo_rd_burst_packer.sv
// fifo_rd_burst_packer
// Read-side consumer of a dual-clock FIFO. It pops words into a small
// 3-entry buffer and emits them as bursts of up to BURST_LEN beats on a
// valid/ready stream. A burst shorter than BURST_LEN is closed by an idle
// timeout, so a trickle of words never stays stuck inside the buffer.
//
// Ports:
//   clk           read-domain clock
//   rst           synchronous, active-high reset
//   fifo_empty    FIFO empty flag
//   fifo_r_valid  pop strobe to the FIFO (never while fifo_empty=1)
//   fifo_r_data   FIFO read data, valid the cycle after a pop
//   m_valid       stream beat valid
//   m_ready       stream sink ready
//   m_data        stream beat data (head of the buffer)
//   m_last        final beat of the current burst
//   beat_idx      position of the current beat inside its burst
module fifo_rd_burst_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_r_valid,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [7:0]            beat_idx
);

    localparam logic [7:0]  LAST_IDX = 8'(BURST_LEN - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_HOLD   = 2'd2,
        S_FLUSH  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] buf_q [3];
    logic [DATA_WIDTH-1:0] buf_d [3];
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [15:0]           timer_q, timer_d;
    logic [7:0]            beat_q, beat_d;

    logic                  at_last_s;
    logic                  xfer_s;
    logic                  pop_s;
    logic [1:0]            wr_idx_s;

    // Head presentation, beat handshake and pop decision.
    always_comb begin
        at_last_s = (beat_q == LAST_IDX);
        // A single buffered word is only shown once a successor is on its
        // way, unless the burst is full or the timeout has forced a flush.
        m_valid   = (occ_q != 2'd0) &&
                    ((occ_q >= 2'd2) || inflight_q || at_last_s || (state_q == S_FLUSH));
        // In FLUSH the head word always closes its burst, even if a newer
        // word lands behind it; that word belongs to the next burst.
        m_last    = m_valid && (at_last_s || (state_q == S_FLUSH));
        m_data    = buf_q[0];
        beat_idx  = beat_q;
        xfer_s    = m_valid && m_ready;
        // Pop only if the word still has a free slot when it lands next cycle.
        pop_s     = !rst && !fifo_empty &&
                    (({1'b0, occ_q} + {2'b00, inflight_q}) <= (3'd2 + {2'b00, xfer_s}));
        fifo_r_valid = pop_s;
    end

    // Buffer shift on transfer, capture of the landed word, counters.
    always_comb begin
        buf_d = buf_q;
        if (xfer_s) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
            wr_idx_s = occ_q - 2'd1;
        end else begin
            wr_idx_s = occ_q;
        end
        if (inflight_q) begin
            case (wr_idx_s)
                2'd0:    buf_d[0] = fifo_r_data;
                2'd1:    buf_d[1] = fifo_r_data;
                2'd2:    buf_d[2] = fifo_r_data;
                default: begin end // no slot 3: the pop rule never lets it happen
            endcase
        end else begin
            wr_idx_s = wr_idx_s;
        end
        occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, xfer_s};
        inflight_d = pop_s;
        if (xfer_s) begin
            beat_d = m_last ? 8'd0 : (beat_q + 8'd1);
        end else begin
            beat_d = beat_q;
        end
    end

    // Burst state machine next-state and idle timer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (inflight_q) begin
                    state_d = S_STREAM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if ((occ_d == 2'd0) && !inflight_d) begin
                    state_d = S_IDLE;
                end else if ((occ_q == 2'd1) && !inflight_q && fifo_empty && !m_valid) begin
                    // Lone word with nothing behind it: withhold it.
                    state_d = S_HOLD;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_HOLD: begin
                if (pop_s) begin
                    state_d = S_STREAM;
                end else if (timer_q >= TMO_LAST) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_FLUSH: begin
                if (xfer_s) begin
                    if ((occ_d == 2'd0) && !inflight_d) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    state_d = S_FLUSH;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_q == S_HOLD) && (state_d == S_HOLD)) begin
            timer_d = timer_q + 16'd1;
        end else begin
            timer_d = 16'd0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            timer_q    <= 16'd0;
            beat_q     <= 8'd0;
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            timer_q    <= timer_d;
            beat_q     <= beat_d;
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_burst_packer.sv
// Testbench for fifo_rd_burst_packer.
// The FIFO is modelled as a queue of words; a second queue holds every word
// written, in order, and each stream beat must match its front. Burst
// framing is checked from first principles: beats are counted since the
// last m_last, a burst must close at BURST_LEN beats, and an early close is
// only legal after the stream has been idle for at least TIMEOUT cycles.
module tb_fifo_rd_burst_packer;

    localparam int DW  = 16;
    localparam int BL  = 8;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_r_valid;
    logic [DW-1:0] fifo_r_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [7:0]    beat_idx;

    always #5 clk = ~clk;

    fifo_rd_burst_packer #(.DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_r_valid (fifo_r_valid),
        .fifo_r_data  (fifo_r_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .beat_idx     (beat_idx)
    );

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];
    logic [DW-1:0] lg_data[$];
    logic          lg_last[$];
    int            lg_idx [$];
    int            lg_gap [$];
    int            lg_cyc [$];

    bit            rst_req     = 1'b0;
    int            ready_mode  = 0;     // 0: always ready, 1: never, 2: random
    int            wr_left     = 0;
    int            wr_prob     = 0;
    int            wr_pause    = 0;
    logic [DW-1:0] wr_next     = '0;
    bit            pop_pending = 1'b0;
    logic [DW-1:0] pop_word    = '0;
    int            pops        = 0;
    int            first_pop_cyc = -1;
    int            cyc         = 0;
    int            model_beat  = 0;
    int            gap         = 0;
    int            beat_gap    = 0;
    bit            prev_hold   = 1'b0;
    logic [DW-1:0] prev_data   = '0;
    logic          prev_last   = 1'b0;

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + DW'(i));
            exp_q.push_back(base + DW'(i));
        end
    endtask

    task automatic clear_log();
        lg_data.delete(); lg_last.delete(); lg_idx.delete(); lg_gap.delete(); lg_cyc.delete();
    endtask

    // One clock cycle: drive inputs at negedge, sample outputs 1 time unit later.
    task automatic step();
        logic          new_beat;
        logic [DW-1:0] exp_w;
        @(negedge clk);
        cyc++;
        rst = rst_req;
        if (rst_req) begin
            fifo_q.delete(); exp_q.delete();
            pop_pending = 1'b0; model_beat = 0; prev_hold = 1'b0; gap = 0;
        end
        if (wr_left > 0) begin
            if (wr_pause > 0) begin
                wr_pause--;
            end else if ($urandom_range(0, 99) < wr_prob) begin
                fifo_q.push_back(wr_next); exp_q.push_back(wr_next);
                wr_next++; wr_left--;
                if ($urandom_range(0, 149) == 0) wr_pause = TMO + 10;
            end
        end
        fifo_empty  = (fifo_q.size() == 0);
        fifo_r_data = pop_pending ? pop_word : DW'($urandom);
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (!rst) begin
            if (fifo_empty) begin
                checks++;
                if (fifo_r_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL pop_while_empty cyc=%0d fifo_r_valid=%b required 0", cyc, fifo_r_valid);
                end
            end
            pop_pending = 1'b0;
            if (fifo_r_valid === 1'b1 && fifo_q.size() > 0) begin
                pop_word = fifo_q.pop_front();
                pop_pending = 1'b1;
                if (pops == 0) first_pop_cyc = cyc;
                pops++;
            end
            if (prev_hold) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                    errors++;
                    $display("FAIL stable cyc=%0d got v=%b d=%h l=%b required v=1 d=%h l=%b",
                             cyc, m_valid, m_data, m_last, prev_data, prev_last);
                end
            end
            new_beat = (m_valid === 1'b1) && !prev_hold;
            if (new_beat) beat_gap = gap;
            gap = (m_valid === 1'b1) ? 0 : gap + 1;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL data cyc=%0d got %h required none (no word outstanding)", cyc, m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (m_data !== exp_w) begin
                        errors++;
                        $display("FAIL data cyc=%0d got %h required %h", cyc, m_data, exp_w);
                    end
                end
                checks++;
                if (beat_idx !== 8'(model_beat)) begin
                    errors++;
                    $display("FAIL beat_idx cyc=%0d got %0d required %0d", cyc, beat_idx, model_beat);
                end
                checks++;
                if (m_last === 1'b1) begin
                    if (!(model_beat == BL - 1 || beat_gap >= TMO)) begin
                        errors++;
                        $display("FAIL last_rule cyc=%0d got m_last=1 at beat %0d idle %0d required full burst or idle>=%0d",
                                 cyc, model_beat, beat_gap, TMO);
                    end
                end else if (model_beat == BL - 1) begin
                    errors++;
                    $display("FAIL missing_last cyc=%0d got m_last=%b required 1 at beat %0d", cyc, m_last, model_beat);
                end
                lg_data.push_back(m_data); lg_last.push_back(m_last);
                lg_idx.push_back(int'(beat_idx)); lg_gap.push_back(beat_gap); lg_cyc.push_back(cyc);
                model_beat = (m_last === 1'b1) ? 0 : model_beat + 1;
            end
            prev_hold = (m_valid === 1'b1) && (m_ready !== 1'b1);
            prev_data = m_data;
            prev_last = m_last;
        end
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        for (int k = 0; k < budget && lg_data.size() < n; k++) step();
        checks++;
        if (lg_data.size() != n) begin
            errors++;
            $display("FAIL %s_count got %0d beats required %0d", name, lg_data.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_req = 1'b1; step(); step();
        rst_req = 1'b0; step();
        checks++;
        if (fifo_r_valid !== 1'b0 || m_valid !== 1'b0 || m_data !== 16'h0000 ||
            m_last !== 1'b0 || beat_idx !== 8'd0) begin
            errors++;
            $display("FAIL reset got r_valid=%b v=%b d=%h l=%b idx=%0d required 0 0 0000 0 0",
                     fifo_r_valid, m_valid, m_data, m_last, beat_idx);
        end
    endtask

    task automatic test_burst();
        ready_mode = 0; pops = 0; first_pop_cyc = -1; clear_log();
        load(16, 16'h0001);
        run_until(16, 100, "burst");
        if (lg_data.size() == 16) begin
            checks++;
            if (lg_cyc[0] - first_pop_cyc != 2) begin
                errors++;
                $display("FAIL burst_latency got %0d cycles required 2", lg_cyc[0] - first_pop_cyc);
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (lg_data[i] !== DW'(i + 1) || lg_idx[i] != i % 8 ||
                    lg_last[i] !== (i % 8 == 7) || lg_cyc[i] != lg_cyc[0] + i) begin
                    errors++;
                    $display("FAIL burst_beat%0d got d=%h idx=%0d l=%b cyc+%0d required d=%h idx=%0d l=%b cyc+%0d",
                             i, lg_data[i], lg_idx[i], lg_last[i], lg_cyc[i] - lg_cyc[0],
                             DW'(i + 1), i % 8, (i % 8 == 7), i);
                end
            end
        end
    endtask

    task automatic test_timeout();
        ready_mode = 0; clear_log();
        load(3, 16'h00A1);
        run_until(3, 200, "timeout");
        if (lg_data.size() == 3) begin
            checks++;
            if (lg_data[2] !== 16'h00A3 || lg_last[0] !== 1'b0 || lg_last[1] !== 1'b0 ||
                lg_last[2] !== 1'b1 || lg_idx[2] != 2) begin
                errors++;
                $display("FAIL timeout_frame got d=%h l=%b%b%b idx=%0d required d=00a3 l=001 idx=2",
                         lg_data[2], lg_last[0], lg_last[1], lg_last[2], lg_idx[2]);
            end
            // Held word: one cycle to see the buffer drain, then TIMEOUT cycles held.
            checks++;
            if (lg_gap[2] < TMO || lg_gap[2] > TMO + 1) begin
                errors++;
                $display("FAIL timeout_idle got %0d idle cycles required %0d..%0d", lg_gap[2], TMO, TMO + 1);
            end
        end
    endtask

    task automatic test_hold_rescue();
        ready_mode = 0; clear_log();
        load(3, 16'h00A1);
        run_until(2, 20, "rescue_first");
        for (int k = 0; k < 30; k++) step();
        load(1, 16'h00A4);
        run_until(4, 200, "rescue");
        if (lg_data.size() == 4) begin
            checks++;
            if (lg_data[2] !== 16'h00A3 || lg_last[2] !== 1'b0 || lg_idx[2] != 2) begin
                errors++;
                $display("FAIL rescue_release got d=%h l=%b idx=%0d required d=00a3 l=0 idx=2",
                         lg_data[2], lg_last[2], lg_idx[2]);
            end
            checks++;
            if (lg_data[3] !== 16'h00A4 || lg_last[3] !== 1'b1 || lg_idx[3] != 3 ||
                lg_gap[3] < TMO || lg_gap[3] > TMO + 1) begin
                errors++;
                $display("FAIL rescue_flush got d=%h l=%b idx=%0d idle=%0d required d=00a4 l=1 idx=3 idle %0d..%0d",
                         lg_data[3], lg_last[3], lg_idx[3], lg_gap[3], TMO, TMO + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        ready_mode = 1; pops = 0; clear_log();
        load(10, 16'h0100);
        for (int k = 0; k < 20; k++) step();
        checks++;
        if (pops != 3) begin
            errors++;
            $display("FAIL bp_pops got %0d required 3", pops);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'h0100) begin
            errors++;
            $display("FAIL bp_head got v=%b d=%h required v=1 d=0100", m_valid, m_data);
        end
        ready_mode = 0;
        run_until(10, 200, "bp");
        if (lg_data.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (lg_data[i] !== 16'h0100 + DW'(i)) begin
                    errors++;
                    $display("FAIL bp_order%0d got %h required %h", i, lg_data[i], 16'h0100 + DW'(i));
                end
            end
            checks++;
            if (lg_last[7] !== 1'b1 || lg_last[9] !== 1'b1) begin
                errors++;
                $display("FAIL bp_last got l7=%b l9=%b required 1 1", lg_last[7], lg_last[9]);
            end
        end
    endtask

    task automatic test_random();
        int len, max_len;
        ready_mode = 2; clear_log();
        wr_next = 16'h1000; wr_prob = 60; wr_pause = 0; wr_left = 1000;
        run_until(1000, 40000, "random");
        wr_left = 0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_lossless got %0d words outstanding required 0", exp_q.size());
        end
        len = 0; max_len = 0;
        foreach (lg_last[i]) begin
            len++;
            if (len > max_len) max_len = len;
            if (lg_last[i] === 1'b1) len = 0;
        end
        checks++;
        if (max_len > BL || max_len < 1) begin
            errors++;
            $display("FAIL random_burst_len got max %0d required 1..%0d", max_len, BL);
        end
    endtask

    task automatic test_midburst_reset();
        ready_mode = 0; clear_log();
        load(12, 16'h0200);
        for (int k = 0; k < 60 && !(m_valid === 1'b1 && beat_idx == 8'd4); k++) step();
        checks++;
        if (!(m_valid === 1'b1 && beat_idx == 8'd4)) begin
            errors++;
            $display("FAIL rst_reach got v=%b idx=%0d required v=1 idx=4", m_valid, beat_idx);
        end
        rst_req = 1'b1; step();
        rst_req = 1'b0; step();
        checks++;
        if (m_valid !== 1'b0 || beat_idx !== 8'd0 || fifo_r_valid !== 1'b0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got v=%b idx=%0d r_valid=%b l=%b required 0 0 0 0",
                     m_valid, beat_idx, fifo_r_valid, m_last);
        end
        clear_log();
        load(3, 16'h0300);
        run_until(3, 200, "rst_next");
        if (lg_data.size() == 3) begin
            checks++;
            if (lg_data[0] !== 16'h0300 || lg_idx[0] != 0 || lg_last[2] !== 1'b1 || lg_idx[2] != 2) begin
                errors++;
                $display("FAIL rst_next_burst got d=%h idx0=%0d l2=%b idx2=%0d required 0300 0 1 2",
                         lg_data[0], lg_idx[0], lg_last[2], lg_idx[2]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; fifo_empty = 1'b1; fifo_r_data = '0; m_ready = 1'b0;
        test_reset();
        test_burst();
        test_timeout();
        test_hold_rescue();
        test_backpressure();
        test_random();
        test_midburst_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
